// File: rtl/zcount_pkg.sv
// Shared constants for the zcount loadable down-counter.
// Holds the default width and the mode encoding.
package zcount_pkg;
  localparam int   ZC_WIDTH_DEF = 14;
  localparam logic ZC_ONESHOT   = 1'b0;
  localparam logic ZC_AUTO      = 1'b1;
endpackage

// File: rtl/zcount_nrn.sv
// N-input NOR zero detector: an OR8 first stage followed by a final NOR.
// Unused inputs of the last OR8 group are tied low.
module nrn #(
  parameter int N = 14
) (
  input  logic [N-1:0] bits,
  output logic         none
);
  localparam int G = (N + 7) / 8;

  logic [G*8-1:0] padded;
  logic [G-1:0]   or8;

  always_comb begin
    padded        = '0;
    padded[N-1:0] = bits;
  end

  for (genvar g = 0; g < G; g++) begin : g_or8
    assign or8[g] = |padded[g*8 +: 8];
  end

  assign none = ~|or8;
endmodule

// File: rtl/zcount.sv
// Loadable down-counter with zero decode, terminal-count pulse and sticky irq.
// Counter priority is ld > dec > hold; decrement at zero is ignored.
module zcount
  import zcount_pkg::*;
#(
  parameter int WIDTH = ZC_WIDTH_DEF
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  input  logic             auto,
  input  logic             rld_wr,
  input  logic [WIDTH-1:0] rld_val,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             irq
);
  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] cnt_x1;
  logic             is_one;
  logic             tc_nxt;

  assign cnt_x1 = count ^ WIDTH'(1);

  nrn #(.N(WIDTH)) u_zero (.bits(count),  .none(zero));
  nrn #(.N(WIDTH)) u_one  (.bits(cnt_x1), .none(is_one));

  always_comb begin
    cnt_nxt = count;
    tc_nxt  = 1'b0;
    if (ld) begin
      cnt_nxt = ld_val;
    end else if (dec && !zero) begin
      if (is_one) begin
        tc_nxt  = 1'b1;
        // reload reads the register value before any same-cycle rld_wr
        cnt_nxt = (auto == ZC_AUTO) ? rld : '0;
      end else begin
        cnt_nxt = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      rld   <= '0;
      tc    <= 1'b0;
      irq   <= 1'b0;
    end else begin
      count <= cnt_nxt;
      tc    <= tc_nxt;
      irq   <= tc_nxt | (irq & ~irq_ack);
      if (rld_wr) rld <= rld_val;
    end
  end
endmodule

// File: tb/tb_zcount.sv
// Self-checking bench for zcount: directed vector table, async reset check,
// then randomized stimulus against a behavioural model.
module tb_zcount;
  localparam int W = 14;

  logic         sys_clk;
  logic         reset;
  logic         ld;
  logic [W-1:0] ld_val;
  logic         dec;
  logic         auto;
  logic         rld_wr;
  logic [W-1:0] rld_val;
  logic         irq_ack;
  logic [W-1:0] count;
  logic         zero;
  logic         tc;
  logic         irq;

  int errors = 0;
  int checks = 0;

  zcount #(.WIDTH(W)) dut (
    .sys_clk(sys_clk), .reset(reset), .ld(ld), .ld_val(ld_val), .dec(dec),
    .auto(auto), .rld_wr(rld_wr), .rld_val(rld_val), .irq_ack(irq_ack),
    .count(count), .zero(zero), .tc(tc), .irq(irq)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic         ld;
    logic [W-1:0] ld_val;
    logic         dec;
    logic         mode;
    logic         rld_wr;
    logic [W-1:0] rld_val;
    logic         irq_ack;
    int           e_count;
    int           e_tc;
    int           e_irq;
    int           e_zero;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int ec, int et, int ei, int ez);
    chk({tag, " count"}, int'(count), ec);
    chk({tag, " tc"},    int'(tc),    et);
    chk({tag, " irq"},   int'(irq),   ei);
    chk({tag, " zero"},  int'(zero),  ez);
  endtask

  task automatic idle_inputs();
    ld = 0; ld_val = '0; dec = 0; auto = 0;
    rld_wr = 0; rld_val = '0; irq_ack = 0;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Behavioural model state
  int m_cnt, m_rld, m_tc, m_irq;

  task automatic model_step(bit i_ld, int i_ldv, bit i_dec, bit i_auto,
                            bit i_rw, int i_rv, bit i_ack);
    int old_rld;
    old_rld = m_rld;
    m_tc = 0;
    if (i_ld) m_cnt = i_ldv;
    else if (i_dec && m_cnt == 1) begin
      m_tc  = 1;
      m_cnt = i_auto ? old_rld : 0;
    end else if (i_dec && m_cnt > 1) m_cnt = m_cnt - 1;
    if (m_tc == 1) m_irq = 1;
    else if (i_ack) m_irq = 0;
    if (i_rw) m_rld = i_rv;
  endtask

  initial begin
    //           ld ldv      dec md rw rv   ack  cnt     tc irq zero
    tbl.push_back('{1, 14'd3,    0, 0, 0, 14'd0, 0, 3,      0, 0, 0}); // one-shot
    tbl.push_back('{0, 14'd0,    1, 0, 0, 14'd0, 0, 2,      0, 0, 0});
    tbl.push_back('{0, 14'd0,    1, 0, 0, 14'd0, 0, 1,      0, 0, 0});
    tbl.push_back('{0, 14'd0,    1, 0, 0, 14'd0, 0, 0,      1, 1, 1});
    tbl.push_back('{0, 14'd0,    1, 0, 0, 14'd0, 0, 0,      0, 1, 1});
    tbl.push_back('{0, 14'd0,    0, 0, 0, 14'd0, 1, 0,      0, 0, 1});
    tbl.push_back('{1, 14'd1,    0, 1, 1, 14'd2, 0, 1,      0, 0, 0}); // auto
    tbl.push_back('{0, 14'd0,    1, 1, 0, 14'd0, 0, 2,      1, 1, 0});
    tbl.push_back('{0, 14'd0,    1, 1, 0, 14'd0, 0, 1,      0, 1, 0});
    tbl.push_back('{0, 14'd0,    1, 1, 1, 14'd7, 0, 2,      1, 1, 0});
    tbl.push_back('{0, 14'd0,    1, 1, 0, 14'd0, 0, 1,      0, 1, 0});
    tbl.push_back('{0, 14'd0,    1, 1, 0, 14'd0, 0, 7,      1, 1, 0});
    tbl.push_back('{1, 14'd1,    0, 1, 0, 14'd0, 0, 1,      0, 1, 0}); // priority
    tbl.push_back('{1, 14'd9,    1, 1, 0, 14'd0, 0, 9,      0, 1, 0});
    tbl.push_back('{1, 14'd1,    0, 0, 0, 14'd0, 0, 1,      0, 1, 0}); // irq ack
    tbl.push_back('{0, 14'd0,    1, 0, 0, 14'd0, 1, 0,      1, 1, 1});
    tbl.push_back('{0, 14'd0,    0, 0, 0, 14'd0, 1, 0,      0, 0, 1});
    tbl.push_back('{1, 14'h3FFF, 0, 0, 0, 14'd0, 0, 'h3FFF, 0, 0, 0}); // width
    tbl.push_back('{0, 14'd0,    1, 0, 0, 14'd0, 0, 'h3FFE, 0, 0, 0});
    tbl.push_back('{1, 14'd0,    0, 0, 0, 14'd0, 0, 0,      0, 0, 1});
    tbl.push_back('{0, 14'd0,    1, 0, 0, 14'd0, 0, 0,      0, 0, 1});
    tbl.push_back('{1, 14'd1,    0, 1, 1, 14'd0, 0, 1,      0, 0, 0}); // rld == 0
    tbl.push_back('{0, 14'd0,    1, 1, 0, 14'd0, 0, 0,      1, 1, 1});
    tbl.push_back('{0, 14'd0,    1, 1, 0, 14'd0, 0, 0,      0, 1, 1});
    tbl.push_back('{1, 14'd1,    0, 1, 1, 14'd1, 0, 1,      0, 1, 0}); // rld == 1
    tbl.push_back('{0, 14'd0,    1, 1, 0, 14'd0, 0, 1,      1, 1, 0});
    tbl.push_back('{0, 14'd0,    1, 1, 0, 14'd0, 0, 1,      1, 1, 0});
    tbl.push_back('{0, 14'd0,    1, 1, 0, 14'd0, 1, 1,      1, 1, 0});

    idle_inputs();
    reset = 1'b1;
    #12;
    chk_all("por", 0, 0, 0, 1);
    @(posedge sys_clk);
    #1 reset = 1'b0;

    // Build irq = 1 and cnt = 5, then hit reset between edges
    ld = 1; ld_val = 14'd1; tick();
    ld = 0; dec = 1; tick();
    dec = 0; ld = 1; ld_val = 14'd5; tick();
    ld = 0;
    chk_all("pre_rst", 5, 0, 1, 0);
    #3 reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 1);
    #2 reset = 1'b0;

    foreach (tbl[i]) begin
      ld = tbl[i].ld; ld_val = tbl[i].ld_val; dec = tbl[i].dec;
      auto = tbl[i].mode; rld_wr = tbl[i].rld_wr; rld_val = tbl[i].rld_val;
      irq_ack = tbl[i].irq_ack;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_count, tbl[i].e_tc,
              tbl[i].e_irq, tbl[i].e_zero);
    end

    idle_inputs();
    reset = 1'b1;
    #3 reset = 1'b0;
    m_cnt = 0; m_rld = 0; m_tc = 0; m_irq = 0;

    for (int n = 0; n < 1500; n++) begin
      ld      = ($urandom_range(0, 9) == 0);
      ld_val  = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
      dec     = ($urandom_range(0, 3) != 0);
      auto    = W'($urandom_range(0, 1)) != 0;
      rld_wr  = ($urandom_range(0, 7) == 0);
      rld_val = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 4));
      irq_ack = ($urandom_range(0, 5) == 0);
      model_step(ld, int'(ld_val), dec, auto, rld_wr, int'(rld_val), irq_ack);
      tick();
      chk_all($sformatf("rnd%0d", n), m_cnt, m_tc, m_irq, (m_cnt == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
